// File: rtl/aes_round_key_scheduler.sv
// AES-128 key schedule engine: expands one round key per cycle into an
// 11-entry buffer and serves registered round-key reads by index.
module aes_round_key_scheduler #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             keys_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t           state, state_nxt;
    logic [3:0]       rnd;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] next_key;
    logic [KEY_W-1:0] rk [0:NUM_ROUNDS];
    logic             accept;
    logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;

    // Row-per-high-nibble table; the low nibble selects the byte, MSB first.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        logic [127:0] sh;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        sh = row >> {~b[3:0], 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign {w0, w1, w2, w3} = work;
    assign t        = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h000000};
    assign n0       = w0 ^ t;
    assign n1       = n0 ^ w1;
    assign n2       = n1 ^ w2;
    assign n3       = n2 ^ w3;
    assign next_key = {n0, n1, n2, n3};

    assign busy       = (state == EXPAND);
    assign keys_valid = (state == READY);
    assign accept     = start && (state != EXPAND);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (rnd == LAST_RND) state_nxt = READY;
            READY:   if (start) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rnd      <= '0;
            work     <= '0;
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (accept) begin
                work <= key_in;
                rnd  <= 4'd1;
            end else if (state == EXPAND) begin
                work <= next_key;
                rnd  <= rnd + 4'd1;
            end
            // A read racing a rekey sees the old buffer: rk updates land after this edge.
            if (rd_en) begin
                if (keys_valid && (rd_round <= LAST_RND)) begin
                    rd_key   <= rk[rd_round];
                    rd_valid <= 1'b1;
                end else begin
                    rd_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rk[0] <= key_in;
        end else if (state == EXPAND) begin
            rk[rnd] <= next_key;
        end
    end

endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// Bench for aes_round_key_scheduler: GF(2^8)-derived key-schedule model with a
// per-cycle output compare, plus directed FIPS-197 and zero-key vectors.
module tb_aes_round_key_scheduler;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, keys_valid;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = '0;
    logic [127:0] rd_key;
    logic         rd_valid, rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    aes_round_key_scheduler #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .keys_valid(keys_valid), .rd_en(rd_en),
        .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference key schedule from first principles (GF inverse + affine map).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Cycle model: a countdown of remaining expansion edges and the key set in service.
    logic         m_kv = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_pend = '0, m_cur = '0, m_rd_key = '0;
    logic         m_rv = 1'b0, m_re = 1'b0;

    task automatic model_step();
        if (!rst_n) begin
            m_kv = 1'b0; m_cnt = 0; m_rd_key = '0; m_rv = 1'b0; m_re = 1'b0;
        end else begin
            m_rv = 1'b0;
            m_re = 1'b0;
            if (rd_en) begin
                if (m_kv && rd_round <= 4'd10) begin
                    m_rd_key = round_key(m_cur, int'(rd_round));
                    m_rv = 1'b1;
                end else begin
                    m_re = 1'b1;
                end
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_kv  = 1'b1;
                    m_cur = m_pend;
                end
            end else if (start) begin
                m_pend = key_in;
                m_cnt  = 10;
                m_kv   = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #2;
        chk("busy", busy, m_cnt > 0);
        chk("keys_valid", keys_valid, m_kv);
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_err", rd_err, m_re);
        chk("rd_key", rd_key, m_rd_key);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_kv(output int cnt);
        cnt = 0;
        while (!keys_valid && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_start(input logic [127:0] k);
        start = 1'b1;
        key_in = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd(input logic [3:0] r, input logic [127:0] exp, input string nm);
        rd_en = 1'b1;
        rd_round = r;
        @(negedge clk);
        rd_en = 1'b0;
        chk(nm, rd_key, exp);
        chk({nm, "_v"}, rd_valid, 1'b1);
    endtask

    int cnt;
    logic [127:0] held;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_kv", keys_valid, 1'b0);
        chk("rst_rd_key", rd_key, '0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("pin_fips_r1", round_key(FIPS_KEY, 1), FIPS_R1);
        chk("pin_fips_r10", round_key(FIPS_KEY, 10), FIPS_R10);
        chk("pin_zero_r1", round_key('0, 1), ZERO_R1);
        chk("pin_zero_r10", round_key('0, 10), ZERO_R10);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 expansion and reads
        do_start(FIPS_KEY);
        chk("t1_busy", busy, 1'b1);
        wait_kv(cnt);
        chk("t1_len", cnt, 10);
        rd(4'd1, FIPS_R1, "t1_r1");
        rd(4'd10, FIPS_R10, "t1_r10");

        // Reverse streaming, rd_en held high
        for (int r = 10; r >= 0; r--) begin
            rd_en = 1'b1;
            rd_round = 4'(r);
            @(negedge clk);
            chk("t3_valid", rd_valid, 1'b1);
            chk("t3_key", rd_key, round_key(FIPS_KEY, r));
        end
        rd_en = 1'b0;
        chk("t3_r0", rd_key, FIPS_KEY);

        // Out-of-range reads in READY
        held = FIPS_KEY;
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1;
            rd_round = (i == 0) ? 4'd11 : 4'd15;
            @(negedge clk);
            chk("t4_err", rd_err, 1'b1);
            chk("t4_valid", rd_valid, 1'b0);
            chk("t4_hold", rd_key, held);
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("t4_idle_err", rd_err, 1'b0);
        chk("t4_idle_valid", rd_valid, 1'b0);

        // Start during EXPAND is ignored; read during EXPAND errors
        do_start(FIPS_KEY);
        repeat (3) @(negedge clk);
        start = 1'b1;
        key_in = ALT_KEY;
        rd_en = 1'b1;
        rd_round = 4'd3;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b0;
        chk("t5_exp_err", rd_err, 1'b1);
        chk("t5_exp_valid", rd_valid, 1'b0);
        chk("t5_exp_hold", rd_key, held);
        wait_kv(cnt);
        chk("t5_len", cnt, 6);
        rd(4'd10, FIPS_R10, "t5_r10");

        // Rekey from READY with a simultaneous read of the old contents
        start = 1'b1;
        key_in = '0;
        rd_en = 1'b1;
        rd_round = 4'd10;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b0;
        chk("t5_rk_read", rd_key, FIPS_R10);
        chk("t5_rk_valid", rd_valid, 1'b1);
        chk("t5_rk_kv", keys_valid, 1'b0);
        wait_kv(cnt);
        chk("t5_rk_len", cnt, 10);
        rd(4'd10, ZERO_R10, "t2_r10");
        rd(4'd0, '0, "t2_r0");
        rd(4'd1, ZERO_R1, "t2_r1");

        // Asynchronous reset mid-expansion
        do_start(FIPS_KEY);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_kv", keys_valid, 1'b0);
        chk("t6_rd_key", rd_key, '0);
        chk("t6_rd_valid", rd_valid, 1'b0);
        chk("t6_rd_err", rd_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        rd_round = 4'd0;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t6_idle_err", rd_err, 1'b1);
        do_start(FIPS_KEY);
        wait_kv(cnt);
        chk("t6_len", cnt, 10);
        rd(4'd1, FIPS_R1, "t6_r1");
        rd(4'd10, FIPS_R10, "t6_r10");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_round_key_scheduler.md
Name: aes_round_key_scheduler

Overview:
Sequential AES-128 key schedule engine and round-key server for the decryption datapath. It expands a 128-bit cipher key iteratively, one round key per cycle, into an internal 11-entry round-key buffer. The inverse-cipher round controller then reads keys by round index, normally 10 down to 0. This replaces the fully combinational 1408-bit expansion with registered storage and a single-round key-schedule step.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported; buffer depth is NUM_ROUNDS+1.
KEY_W, 128, width of the cipher key and of each round key.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to expand key_in.
key_in  input  KEY_W  cipher key, sampled on the start-accept edge; w0 = key_in[127:96].
busy  output  1  high while expansion is in progress.
keys_valid  output  1  high when all 11 round keys are stored and readable.
rd_en  input  1  round-key read request.
rd_round  input  4  round index to read, 0..10.
rd_key  output  KEY_W  registered round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
rd_valid  output  1  one-cycle pulse; rd_key is valid.
rd_err  output  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset, asynchronous on rst_n=0: state IDLE, round counter 0, busy=0, keys_valid=0, rd_key=0, rd_valid=0, rd_err=0. Buffer contents need not be cleared but are unreadable until keys_valid=1. Reset asserted mid-expansion aborts it immediately.
- States: IDLE, EXPAND, READY.
- IDLE -> EXPAND: start=1 at an edge. That edge writes rk[0]=key_in, sets rnd=1, busy=1, keys_valid=0.
- READY -> EXPAND: start=1 behaves the same (rekey). keys_valid drops at that edge.
- EXPAND: each edge computes rk[rnd] from rk[rnd-1] as follows:
  - t = SubWord(RotWord(w3)) ^ Rcon(rnd), with Rcon = 01,02,04,08,10,20,40,80,1B,36 in the top byte.
  - n0 = w0^t, n1 = n0^w1, n2 = n1^w2, n3 = n2^w3.
  - The previous key is held in a working register, not re-read from the buffer. rnd increments each edge.
- Exit from EXPAND: the edge that writes rk[10] moves the state to READY, sets busy=0 and keys_valid=1. With start sampled at edge E0, keys_valid is first seen high after edge E10, so expansion takes 11 edges including the accept edge.
- start while in EXPAND is ignored and does not restart expansion.
- SubWord uses 4 parallel forward S-box lookups (combinational case function). Rcon comes from an rnd-indexed case.
- Read, accepted at an edge where rd_en=1, keys_valid=1 and rd_round<=10: rd_key <= rk[rd_round] and rd_valid=1 for one cycle. Latency is 1 cycle. Back-to-back reads on every cycle are supported.
- Read with rd_en=1 and rd_round>10 while keys_valid=1: rd_err=1 for one cycle, rd_valid=0, rd_key holds its previous value.
- Read with rd_en=1 while keys_valid=0 (IDLE or EXPAND): rd_err=1, rd_valid=0.
- Simultaneous start and rd_en in READY: the read is served from the pre-rekey contents (same-edge nonblocking semantics), and expansion begins.
- rd_valid and rd_err are never high together. When rd_en=0, both are 0 on the next cycle.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy high for 10 cycles. Then keys_valid=1 exactly after the 11th edge. Read rd_round=1 -> a0fafe1788542cb123a339392a6c7605. Read rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. All-zero key -> round 0 = 0; round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Reverse streaming: rd_en held for 11 cycles, rd_round 10 down to 0 -> rd_valid high for 11 consecutive cycles with the correct keys, round 0 equal to key_in.
4. Errors: rd_en during EXPAND, and rd_round=11 or 15 in READY -> rd_err pulses, rd_valid=0, rd_key unchanged.
5. Start re-issued in EXPAND, at cycle 5 with a different key -> ignored; final keys match the first key. Then rekey from READY with the zero key -> keys_valid drops for 10 cycles, then round 10 = b4ef5bcb....
6. rst_n pulsed low at cycle 4 of expansion -> all outputs 0 asynchronously, state IDLE. A new start then yields correct FIPS-197 keys.
